psg_core_multi: RTL and testbench
=================================

Name: psg_core_multi

Overview:
- Parametrised AY-3-8913-style PSG core with a register bank, NUM_CHANNELS square-wave tone generators, one shared LFSR noise generator, a per-channel mixer with fixed amplitudes, a channel summer and a PWM DAC output.
- Next generation of the register-file-only block: channel count is generalised, and the core now generates actual audio.
- Sits behind the top-level pin wrapper: data_in comes from ui_in, pwm_out/mix_out drive uo_out.

Parameters:
- NUM_CHANNELS, 3, number of tone channels; legal range 1..4.
- PRESCALE, 16, clk cycles per tone tick; must be ≥2. Noise ticks at half the tone-tick rate.
- TONE_BITS, 12, tone period width; must be ≤12.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_in  in  8  address or data byte
- latch_addr  in  1  strobe: data_in[3:0] becomes the selected register
- write_en  in  1  strobe: data_in is written to the selected register
- data_out  out  8  readback of the selected register, registered
- tone_out  out  NUM_CHANNELS  raw square wave for each channel
- noise_out  out  1  raw noise bit
- level_out  out  4*NUM_CHANNELS  mixed 4-bit level per channel; channel i is at [4i+3:4i]
- mix_out  out  MIX_BITS  sum of all levels, registered. MIX_BITS = 4 + $clog2(NUM_CHANNELS) (localparam).
- pwm_out  out  1  PWM of mix_out

Behaviour:
- Reset values:
  - All registers 0; selected register address 0; data_out 0.
  - Prescaler and all counters 0; tone_out all 0.
  - LFSR = 17'h00001, so noise_out = 1.
  - level_out, mix_out, pwm_out all 0.
- Register map (N = NUM_CHANNELS; addresses are the selected register address):
  - 2i: tone i fine period [7:0].
  - 2i+1: tone i coarse period [TONE_BITS-9:0].
  - 2N: noise period [4:0].
  - 2N+1: mixer. Bit i = tone i disable; bit N+i = noise disable for channel i.
  - 2N+2+i: channel i amplitude [3:0]; bit 4 is stored but ignored (envelope reserved).
  - With N=3 this is exactly the AY R0–R10 layout.
  - Writes to unmapped addresses are dropped. Unmapped addresses, and unimplemented bits of mapped ones, read back as 0.
- Bus protocol:
  - latch_addr: selected register <= data_in[3:0] on that clk edge.
  - write_en: selected register <= data_in (masked to implemented bits) on that edge.
  - Both strobes high in the same cycle: the address latch wins; no write occurs.
  - data_out: one cycle after any change, equals the masked contents of the selected register. A write is visible the next cycle.
- Prescaler:
  - tick pulses for one clk every PRESCALE cycles: first at cycle PRESCALE-1 after reset, then every PRESCALE.
  - ntick = every second tick.
- Tone channel i:
  - Effective period P = max(period_i, 1).
  - On each tick: if cnt+1 ≥ P then cnt <= 0 and tone_out[i] toggles; else cnt <= cnt+1.
  - Result: half-period = P ticks.
  - A period change takes effect immediately. If the new P ≤ cnt+1, the counter wraps on the next tick (no long wrap-around).
- Noise:
  - 5-bit counter with the same compare rule against max(noise_period, 1), advanced on ntick.
  - On wrap: lfsr <= {lfsr[0]^lfsr[3], lfsr[16:1]}.
  - noise_out = lfsr[0].
  - The LFSR never reaches 0.
- Mixer:
  - on_i = (tone_out[i] | tdis_i) & (noise_out | ndis_i).
  - level_i = on_i ? amp_i : 0.
  - level_out is registered: 1 clk after a tone/noise/register change.
  - mix_out = sum of level_out, registered one more clk later (2 clk total). No saturation is needed (width is sufficient).
- PWM:
  - Free-running MIX_BITS counter, wrapping at 2^MIX_BITS.
  - pwm_out <= (pwm_cnt < mix_out), registered.
  - Duty cycle = mix_out / 2^MIX_BITS. mix_out = 0 gives constant 0.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Strobes are ignored while reset is high.

Test Plan:
- latch 0x03, write 0xFF; latch 0x0F, write 0x55; latch 0x03 -> data_out = 0x0F (coarse masked to 4 bits); latch 0x0F -> data_out = 0x00; a write with latch_addr=1 in the same cycle leaves the register unchanged.
- PRESCALE=16, tone0 period=2 -> tone_out[0] toggles every 32 clk; period 0 and period 1 both toggle every 16 clk; change the period 5 -> 1 mid-count -> toggle at the next tick.
- Noise period=1 -> LFSR steps every 32 clk; first 5 noise_out values after reset = 1,0,0,0,0; the state is never all-zero over 2^17 steps.
- Mixer 0x3F, amp A=0xF, B=0x8, C=0x1 -> level_out = {1,8,F}; 2 clk later mix_out = 24.
- Mixer 0x38 (noise off, tones on), amp A=0xA -> level_out[3:0] alternates between 0xA and 0 in step with tone_out[0].
- mix_out = 16 with MIX_BITS=6 -> pwm_out high for 16 of every 64 clk; assert reset mid-tone -> tone_out = 0, LFSR = 1, mix_out = 0 next cycle.

Source files
------------

// File: rtl/psg_core_multi.sv
// Multi-channel PSG core: register bank, tone/noise generators, mixer, summer and PWM DAC.
// Latency: level_out 1 clk after a change, mix_out 2 clk, pwm_out 3 clk. No backpressure.
module psg_core_multi #(
  parameter int NUM_CHANNELS = 3,
  parameter int PRESCALE     = 16,
  parameter int TONE_BITS    = 12,
  localparam int MIX_BITS    = 4 + $clog2(NUM_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                data_in,
  input  logic                      latch_addr,
  input  logic                      write_en,
  output logic [7:0]                data_out,
  output logic [NUM_CHANNELS-1:0]   tone_out,
  output logic                      noise_out,
  output logic [4*NUM_CHANNELS-1:0] level_out,
  output logic [MIX_BITS-1:0]       mix_out,
  output logic                      pwm_out
);
  localparam int MIXW = 2 * NUM_CHANNELS;
  localparam int PW   = $clog2(PRESCALE);
  localparam logic [11:0] PMASK = 12'((1 << TONE_BITS) - 1);

  logic [3:0]      sel;
  logic [11:0]     period [NUM_CHANNELS];
  logic [4:0]      amp [NUM_CHANNELS];
  logic [4:0]      noise_per;
  logic [MIXW-1:0] mixer;
  logic [7:0]      rd_val;

  // Address latch has priority over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= '0;
      noise_per <= '0;
      mixer     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        period[i] <= '0;
        amp[i]    <= '0;
      end
    end else if (latch_addr) begin
      sel <= data_in[3:0];
    end else if (write_en) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (sel == 4'(2*i))
          period[i] <= {period[i][11:8], data_in} & PMASK;
        if (sel == 4'(2*i+1))
          period[i] <= {data_in[3:0], period[i][7:0]} & PMASK;
        if (sel == 4'(2*NUM_CHANNELS+2+i))
          amp[i] <= data_in[4:0];
      end
      if (sel == 4'(2*NUM_CHANNELS))
        noise_per <= data_in[4:0];
      if (sel == 4'(2*NUM_CHANNELS+1))
        mixer <= data_in[MIXW-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (sel == 4'(2*i))                rd_val = period[i][7:0];
      if (sel == 4'(2*i+1))              rd_val = {4'b0, period[i][11:8]};
      if (sel == 4'(2*NUM_CHANNELS+2+i)) rd_val = {3'b0, amp[i]};
    end
    if (sel == 4'(2*NUM_CHANNELS))   rd_val = {3'b0, noise_per};
    if (sel == 4'(2*NUM_CHANNELS+1)) rd_val = 8'(mixer);
  end

  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else       data_out <= rd_val;
  end

  logic [PW-1:0] pre_cnt;
  logic          tick, phase, ntick;

  assign tick  = (pre_cnt == PW'(PRESCALE-1));
  assign ntick = tick & phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      pre_cnt <= '0;
      phase   <= ~phase;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  logic [11:0]             tcnt [NUM_CHANNELS];
  logic [11:0]             peff [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] twrap;

  // ">=" rather than "==" so a shortened period wraps on the next tick.
  always_comb begin
    twrap = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      peff[i]  = (period[i] == 12'd0) ? 12'd1 : period[i];
      twrap[i] = ({1'b0, tcnt[i]} + 13'd1) >= {1'b0, peff[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_out <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) tcnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (twrap[i]) begin
          tcnt[i]     <= '0;
          tone_out[i] <= ~tone_out[i];
        end else begin
          tcnt[i] <= tcnt[i] + 12'd1;
        end
      end
    end
  end

  logic [4:0]  ncnt, neff;
  logic [16:0] lfsr;
  logic        nwrap;

  assign neff      = (noise_per == 5'd0) ? 5'd1 : noise_per;
  assign nwrap     = ({1'b0, ncnt} + 6'd1) >= {1'b0, neff};
  assign noise_out = lfsr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ncnt <= '0;
      lfsr <= 17'h00001;
    end else if (ntick) begin
      if (nwrap) begin
        ncnt <= '0;
        lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        ncnt <= ncnt + 5'd1;
      end
    end
  end

  logic [4*NUM_CHANNELS-1:0] level_c;
  logic [MIX_BITS-1:0]       sum_c;
  logic [MIX_BITS-1:0]       pwm_cnt;

  always_comb begin
    level_c = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if ((tone_out[i] | mixer[i]) & (noise_out | mixer[NUM_CHANNELS+i]))
        level_c[4*i +: 4] = amp[i][3:0];
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      sum_c = sum_c + MIX_BITS'(level_out[4*i +: 4]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_out <= '0;
      mix_out   <= '0;
      pwm_cnt   <= '0;
      pwm_out   <= 1'b0;
    end else begin
      level_out <= level_c;
      mix_out   <= sum_c;
      pwm_cnt   <= pwm_cnt + 1'b1;
      pwm_out   <= (pwm_cnt < mix_out);
    end
  end

endmodule

// File: tb/tb_psg_core_multi.sv
// Directed bench for psg_core_multi (3 channels, prescale 16) with a scoreboard queue.
module tb_psg_core_multi;
  localparam int N  = 3;
  localparam int MB = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic          latch_addr = 1'b0;
  logic          write_en = 1'b0;
  logic [7:0]    data_out;
  logic [N-1:0]  tone_out;
  logic          noise_out;
  logic [4*N-1:0] level_out;
  logic [MB-1:0] mix_out;
  logic          pwm_out;

  psg_core_multi #(.NUM_CHANNELS(N), .PRESCALE(16), .TONE_BITS(12)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .latch_addr(latch_addr),
    .write_en(write_en), .data_out(data_out), .tone_out(tone_out),
    .noise_out(noise_out), .level_out(level_out), .mix_out(mix_out),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic latch(input logic [7:0] a);
    data_in = a;
    latch_addr = 1'b1;
    step();
    latch_addr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    data_in = d;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
  endtask

  task automatic setreg(input logic [7:0] a, input logic [7:0] d);
    latch(a);
    wr(d);
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
    latch(a);
    expect_val(tag, {24'h0, exp});
    step();
    check({24'h0, data_out});
  endtask

  task automatic wait_tone(output int n);
    logic p;
    p = tone_out[0];
    n = 0;
    do begin
      step();
      n++;
    end while (tone_out[0] === p && n < 1000);
  endtask

  task automatic wait_noise(output int n);
    logic p;
    p = noise_out;
    n = 0;
    do begin
      step();
      n++;
    end while (noise_out === p && n < 1000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          hi;
    logic        t;
    logic [16:0] m;

    steps(2);
    reset = 1'b0;
    expect_val("rst_data_out", 0);  check({24'h0, data_out});
    expect_val("rst_tone", 0);      check({29'h0, tone_out});
    expect_val("rst_noise", 1);     check({31'h0, noise_out});
    expect_val("rst_level", 0);     check({20'h0, level_out});
    expect_val("rst_mix", 0);       check({26'h0, mix_out});
    expect_val("rst_pwm", 0);       check({31'h0, pwm_out});

    // First LFSR step lands on the second prescaler tick.
    wait_noise(n);
    expect_val("noise_first_step", 32); check(n);
    m = 17'h10000;
    for (int k = 0; k < 40; k++) begin
      steps(16);
      expect_val("noise_seq", {31'h0, m[0]});
      check({31'h0, noise_out});
      steps(16);
      m = {m[0] ^ m[3], m[16:1]};
    end

    setreg(8'h03, 8'hFF);
    setreg(8'h0F, 8'h55);
    rd(8'h03, "coarse_mask", 8'h0F);
    rd(8'h0F, "unmapped", 8'h00);
    data_in = 8'h07;
    latch_addr = 1'b1;
    write_en = 1'b1;
    step();
    latch_addr = 1'b0;
    write_en = 1'b0;
    expect_val("both_strobes_no_write", 0);
    step();
    check({24'h0, data_out});
    rd(8'h03, "both_strobes_keep", 8'h0F);
    wr(8'h0A);
    expect_val("write_visible", 8'h0A);
    step();
    check({24'h0, data_out});
    setreg(8'h08, 8'h1F);
    rd(8'h08, "amp_bit4", 8'h1F);
    setreg(8'h07, 8'hFF);
    rd(8'h07, "mixer_mask", 8'h3F);
    setreg(8'h06, 8'hFF);
    rd(8'h06, "noise_per_mask", 8'h1F);
    setreg(8'h06, 8'h01);

    setreg(8'h01, 8'h00);
    setreg(8'h00, 8'h02);
    wait_tone(n);
    wait_tone(n);
    expect_val("tone_p2", 32); check(n);
    setreg(8'h00, 8'h00);
    wait_tone(n);
    wait_tone(n);
    expect_val("tone_p0", 16); check(n);
    setreg(8'h00, 8'h01);
    wait_tone(n);
    wait_tone(n);
    expect_val("tone_p1", 16); check(n);

    // Period 5 -> 1 with the counter at 2: wrap on the very next tick.
    setreg(8'h00, 8'h05);
    wait_tone(n);
    steps(38);
    latch(8'h00);
    wr(8'h01);
    wait_tone(n);
    expect_val("tone_shorten", 8); check(n);

    setreg(8'h08, 8'h0F);
    setreg(8'h09, 8'h08);
    setreg(8'h0A, 8'h01);
    setreg(8'h07, 8'h3F);
    step();
    expect_val("level_all_on", 12'h18F); check({20'h0, level_out});
    step();
    expect_val("mix_sum", 24); check({26'h0, mix_out});

    setreg(8'h08, 8'h0A);
    setreg(8'h07, 8'h38);
    wait_tone(n);
    t = tone_out[0];
    for (int k = 0; k < 6; k++) begin
      steps(8);
      expect_val("level_follows_tone", ((t ^ k[0]) == 1'b1) ? 32'hA : 32'h0);
      check({28'h0, level_out[3:0]});
      steps(8);
    end

    setreg(8'h08, 8'h08);
    setreg(8'h09, 8'h08);
    setreg(8'h0A, 8'h00);
    setreg(8'h07, 8'h3F);
    steps(3);
    expect_val("mix_16", 16); check({26'h0, mix_out});
    hi = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (pwm_out) hi++;
    end
    expect_val("pwm_duty", 16); check(hi);

    setreg(8'h07, 8'h38);
    steps(5);
    reset = 1'b1;
    data_in = 8'h05;
    latch_addr = 1'b1;
    write_en = 1'b1;
    step();
    expect_val("mid_rst_tone", 0);  check({29'h0, tone_out});
    expect_val("mid_rst_noise", 1); check({31'h0, noise_out});
    expect_val("mid_rst_level", 0); check({20'h0, level_out});
    expect_val("mid_rst_mix", 0);   check({26'h0, mix_out});
    expect_val("mid_rst_pwm", 0);   check({31'h0, pwm_out});
    latch_addr = 1'b0;
    write_en = 1'b0;
    reset = 1'b0;
    step();
    expect_val("mid_rst_reg0", 0);  check({24'h0, data_out});
    rd(8'h06, "mid_rst_noise_per", 8'h00);
    rd(8'h05, "mid_rst_strobe_ignored", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
